// File: rtl/p_cal_tdm_nph_pkg.sv
// Shared types, core latencies and IEEE-754 single helpers
// for the time-multiplexed N-phase power calculator.
package p_cal_tdm_nph_pkg;

  localparam int SINGLE        = 32;
  localparam int MUL_NODSP_LAT = 5;
  localparam int ADD_NODSP_LAT = 7;
  localparam logic ENA_MATH    = 1'b1;
  localparam logic ADD_OP      = 1'b1;

  typedef logic [SINGLE-1:0] fp_t;

  localparam fp_t FP_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_MWAIT,
    S_ACC,
    S_DONE
  } state_e;

  function automatic fp_t fp_round(
    input logic              s,
    input logic signed [10:0] e,
    input logic [23:0]       m,
    input logic              g,
    input logic              st
  );
    logic [24:0]        r;
    logic signed [10:0] ex;
    r  = {1'b0, m} + {24'd0, g & (st | m[0])};
    ex = e;
    if (r[24]) begin
      r  = r >> 1;
      ex = ex + 11'sd1;
    end
    if (ex >= 11'sd255) return {s, 8'hFF, 23'd0};
    if (ex <= 11'sd0) return {s, 31'd0};
    return {s, ex[7:0], r[22:0]};
  endfunction

  function automatic fp_t fp_mul(input fp_t a, input fp_t b);
    logic               s;
    logic [47:0]        p;
    logic signed [10:0] e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
      return {s, 8'hFF, 23'd0};
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
      return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({3'd0, a[30:23]})
      + $signed({3'd0, b[30:23]}) - 11'sd127;
    if (p[47])
      return fp_round(s, e + 11'sd1, p[47:24],
                      p[23], |p[22:0]);
    return fp_round(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic fp_t fp_add(input fp_t a, input fp_t b);
    fp_t                x;
    fp_t                y;
    logic [26:0]        mx;
    logic [26:0]        my;
    logic [26:0]        lost;
    logic [27:0]        sum;
    logic [7:0]         d;
    logic [4:0]         lz;
    logic signed [10:0] e;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0)
      return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    // sticky collapses every bit shifted out of the smaller operand
    if (d > 8'd26) begin
      my = 27'd1;
    end else begin
      lost = my << (8'd27 - d);
      my   = (my >> d) | {26'd0, |lost};
    end
    if (x[31] ^ y[31]) sum = {1'b0, mx} - {1'b0, my};
    else sum = {1'b0, mx} + {1'b0, my};
    if (sum == 28'd0) return FP_ZERO;
    e = $signed({3'd0, x[30:23]});
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 11'sd1;
    end else begin
      lz = 5'd0;
      for (int i = 0; i < 27; i++)
        if (sum[i]) lz = 5'(26 - i);
      sum = sum << lz;
      e   = e - $signed({6'd0, lz});
    end
    return fp_round(x[31], e, sum[26:3], sum[2], |sum[1:0]);
  endfunction

endpackage

// File: rtl/p_cal_tdm_nph_if.sv
// Request/result bundle between the V/I sample stage
// and the power calculator.
interface p_cal_tdm_nph_if #(
  parameter int N_PH = 3
);
  import p_cal_tdm_nph_pkg::*;

  logic                   sta;
  logic [N_PH*SINGLE-1:0] V;
  logic [N_PH*SINGLE-1:0] I;
  logic [N_PH-1:0]        ph_en;
  logic                   ovr_clr;
  fp_t                    P;
  logic                   done_sig;
  logic                   busy;
  logic                   ovr;

  modport master (
    output sta, V, I, ph_en, ovr_clr,
    input  P, done_sig, busy, ovr
  );

  modport slave (
    input  sta, V, I, ph_en, ovr_clr,
    output P, done_sig, busy, ovr
  );

endinterface

// File: rtl/Adder_nodsp.sv
// Pipelined IEEE-754 single adder/subtractor, round-nearest-even,
// denormals flushed to zero.
module Adder_nodsp
  import p_cal_tdm_nph_pkg::*;
#(
  parameter int LAT = ADD_NODSP_LAT
) (
  input  logic aclr,
  input  logic add_sub,
  input  logic clk_en,
  input  logic clock,
  input  fp_t  dataa,
  input  fp_t  datab,
  output fp_t  result
);

  fp_t pipe_q [LAT];
  fp_t b_eff;

  assign b_eff = add_sub ? datab
               : {~datab[SINGLE-1], datab[SINGLE-2:0]};

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int k = 0; k < LAT; k++) pipe_q[k] <= FP_ZERO;
    end else if (clk_en) begin
      pipe_q[0] <= fp_add(dataa, b_eff);
      for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign result = pipe_q[LAT-1];

endmodule

// File: rtl/Multiplier_nodsp_dsp.sv
// Pipelined IEEE-754 single multiplier, round-nearest-even,
// denormals flushed to zero.
module Multiplier_nodsp_dsp
  import p_cal_tdm_nph_pkg::*;
#(
  parameter int LAT = MUL_NODSP_LAT
) (
  input  logic aclr,
  input  logic clk_en,
  input  logic clock,
  input  fp_t  dataa,
  input  fp_t  datab,
  output fp_t  result
);

  fp_t pipe_q [LAT];

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int k = 0; k < LAT; k++) pipe_q[k] <= FP_ZERO;
    end else if (clk_en) begin
      pipe_q[0] <= fp_mul(dataa, datab);
      for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign result = pipe_q[LAT-1];

endmodule

// File: rtl/p_cal_tdm_seq.sv
// Sequencer: phase issue, product capture tags, accumulate
// schedule and busy/overrun status.
module p_cal_tdm_seq
  import p_cal_tdm_nph_pkg::*;
#(
  parameter int N_PH    = 3,
  parameter int MUL_LAT = MUL_NODSP_LAT,
  parameter int ADD_LAT = ADD_NODSP_LAT,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sta,
  input  logic             ovr_clr,
  output logic             lat,
  output logic             mul_iss,
  output logic [CNT_W-1:0] mul_idx,
  output logic             cap_vld,
  output logic [CNT_W-1:0] cap_idx,
  output logic             add_iss,
  output logic             add_first,
  output logic [CNT_W-1:0] add_idx,
  output logic             done,
  output logic             busy,
  output logic             ovr
);

  localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(N_PH - 1);
  localparam logic [CNT_W-1:0] MW_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] AW_LAST = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ph_q, ph_d;
  logic [CNT_W-1:0] wt_q, wt_d;
  logic             ovr_q, ovr_d;
  logic [MUL_LAT-1:0] tv_q;
  logic [CNT_W-1:0]   ti_q [MUL_LAT];

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    wt_d    = wt_q;
    ovr_d   = ovr_q;
    lat     = 1'b0;
    mul_iss = 1'b0;
    add_iss = 1'b0;
    done    = 1'b0;
    if (ovr_clr) ovr_d = 1'b0;
    if (sta && state_q != S_IDLE) ovr_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (sta) begin
          lat     = 1'b1;
          ph_d    = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        mul_iss = 1'b1;
        if (ph_q == PH_LAST) begin
          wt_d    = '0;
          state_d = S_MWAIT;
        end else begin
          ph_d = ph_q + ONE;
        end
      end
      S_MWAIT: begin
        if (wt_q == MW_LAST) begin
          wt_d    = '0;
          ph_d    = ONE;
          state_d = (N_PH == 1) ? S_DONE : S_ACC;
        end else begin
          wt_d = wt_q + ONE;
        end
      end
      S_ACC: begin
        // one add in flight; the next one issues as its sum emerges
        add_iss = (wt_q == '0);
        if (wt_q == AW_LAST) begin
          wt_d = '0;
          if (ph_q == PH_LAST) state_d = S_DONE;
          else ph_d = ph_q + ONE;
        end else begin
          wt_d = wt_q + ONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      wt_q    <= '0;
      ovr_q   <= 1'b0;
      tv_q    <= '0;
      for (int k = 0; k < MUL_LAT; k++) ti_q[k] <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      wt_q    <= wt_d;
      ovr_q   <= ovr_d;
      tv_q[0] <= mul_iss;
      ti_q[0] <= ph_q;
      for (int k = 1; k < MUL_LAT; k++) begin
        tv_q[k] <= tv_q[k-1];
        ti_q[k] <= ti_q[k-1];
      end
    end
  end

  assign mul_idx   = ph_q;
  assign add_idx   = ph_q;
  assign add_first = (ph_q == ONE);
  assign cap_vld   = tv_q[MUL_LAT-1];
  assign cap_idx   = ti_q[MUL_LAT-1];
  assign busy      = (state_q != S_IDLE);
  assign ovr       = ovr_q;

endmodule

// File: rtl/p_cal_tdm_nph.sv
// N-phase active power P = sum(en ? V*I : 0) on one shared
// FP multiplier and one shared FP adder.
module p_cal_tdm_nph
  import p_cal_tdm_nph_pkg::*;
#(
  parameter int N_PH    = 3,
  parameter int MUL_LAT = MUL_NODSP_LAT,
  parameter int ADD_LAT = ADD_NODSP_LAT,
  parameter int CNT_W   = 5
) (
  input logic            clk,
  input logic            rst,
  p_cal_tdm_nph_if.slave bus
);

  fp_t             v_q [N_PH];
  fp_t             v_d [N_PH];
  fp_t             i_q [N_PH];
  fp_t             i_d [N_PH];
  fp_t             prod_q [N_PH];
  fp_t             prod_d [N_PH];
  logic [N_PH-1:0] en_q, en_d;
  fp_t             p_q, p_d;

  logic             lat, mul_iss, cap_vld;
  logic             add_iss, add_first, done;
  logic [CNT_W-1:0] mul_idx, cap_idx, add_idx;
  fp_t              mul_a, mul_b, mul_res;
  fp_t              add_a, add_b, add_res, acc;

  p_cal_tdm_seq #(
    .N_PH    (N_PH),
    .MUL_LAT (MUL_LAT),
    .ADD_LAT (ADD_LAT),
    .CNT_W   (CNT_W)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .sta       (bus.sta),
    .ovr_clr   (bus.ovr_clr),
    .lat       (lat),
    .mul_iss   (mul_iss),
    .mul_idx   (mul_idx),
    .cap_vld   (cap_vld),
    .cap_idx   (cap_idx),
    .add_iss   (add_iss),
    .add_first (add_first),
    .add_idx   (add_idx),
    .done      (done),
    .busy      (bus.busy),
    .ovr       (bus.ovr)
  );

  always_comb begin
    en_d  = en_q;
    mul_a = FP_ZERO;
    mul_b = FP_ZERO;
    add_b = FP_ZERO;
    for (int k = 0; k < N_PH; k++) begin
      v_d[k]    = v_q[k];
      i_d[k]    = i_q[k];
      prod_d[k] = prod_q[k];
      if (lat) begin
        v_d[k] = bus.V[k*SINGLE +: SINGLE];
        i_d[k] = bus.I[k*SINGLE +: SINGLE];
      end
      // a masked phase multiplies by +0.0 so the schedule stays fixed
      if (mul_iss && mul_idx == CNT_W'(k)) begin
        mul_a = v_q[k];
        mul_b = en_q[k] ? i_q[k] : FP_ZERO;
      end
      if (cap_vld && cap_idx == CNT_W'(k))
        prod_d[k] = mul_res;
      if (add_iss && add_idx == CNT_W'(k))
        add_b = prod_q[k];
    end
    if (lat) en_d = bus.ph_en;
    add_a = FP_ZERO;
    if (add_iss) add_a = add_first ? prod_q[0] : add_res;
    acc = (N_PH == 1) ? prod_q[0] : add_res;
    p_d = done ? acc : p_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= '0;
      p_q  <= FP_ZERO;
      for (int k = 0; k < N_PH; k++) begin
        v_q[k]    <= FP_ZERO;
        i_q[k]    <= FP_ZERO;
        prod_q[k] <= FP_ZERO;
      end
    end else begin
      en_q <= en_d;
      p_q  <= p_d;
      for (int k = 0; k < N_PH; k++) begin
        v_q[k]    <= v_d[k];
        i_q[k]    <= i_d[k];
        prod_q[k] <= prod_d[k];
      end
    end
  end

  Multiplier_nodsp_dsp #(.LAT(MUL_LAT)) u_mul (
    .aclr   (rst),
    .clk_en (ENA_MATH),
    .clock  (clk),
    .dataa  (mul_a),
    .datab  (mul_b),
    .result (mul_res)
  );

  Adder_nodsp #(.LAT(ADD_LAT)) u_add (
    .aclr    (rst),
    .add_sub (ADD_OP),
    .clk_en  (ENA_MATH),
    .clock   (clk),
    .dataa   (add_a),
    .datab   (add_b),
    .result  (add_res)
  );

  assign bus.P        = done ? acc : p_q;
  assign bus.done_sig = done;

endmodule
